// File: rtl/alu_pkg.sv
// Shared definitions for the ALU stage and its downstream result serializer.
package alu_pkg;

  localparam int ALU_LAT = 2;
  localparam int RES_W   = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HI   = 2'd1,
    LO   = 2'd2
  } ser_state_e;

  // Byte select of a result word; hi=1 returns the upper byte.
  function automatic logic [7:0] res_byte(input logic [RES_W-1:0] res, input logic hi);
    return hi ? res[RES_W-1 -: 8] : res[7:0];
  endfunction

endpackage

// File: rtl/alu_res_fifo.sv
// Synchronous FIFO with sync clear; pointers carry an extra wrap bit to tell full from empty.
module alu_res_fifo
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 16
) (
  input  logic                     clk_p_i,
  input  logic                     reset_n_i,
  input  logic                     clear_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         push_data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         head_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             do_push, do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign count_o = wr_ptr_q - rd_ptr_q;
  assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q[AW-1:0]] = push_data_i;
        wr_ptr_d                = wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_p_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: rtl/alu_result_serializer.sv
// Tags ALU results via a delay-matched issue strobe, buffers them, and streams
// each 16-bit result as two bytes (high first) over a valid/ready link.
module alu_result_serializer
  import alu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int LAT   = ALU_LAT
) (
  input  logic                     clk_p_i,
  input  logic                     reset_n_i,
  input  logic                     issue_valid_i,
  input  logic [RES_W-1:0]         alu_data_i,
  input  logic                     flush_i,
  output logic [7:0]               byte_o,
  output logic                     byte_valid_o,
  input  logic                     byte_ready_i,
  output logic                     byte_last_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     overflow_o
);

  logic [LAT-1:0]   dly_q, dly_d;
  logic [RES_W-1:0] hold_q, hold_d;
  ser_state_e       state_q, state_d;
  logic             overflow_q, overflow_d;

  logic             res_valid;
  logic             fifo_push, fifo_pop;
  logic             fifo_full, fifo_empty;
  logic [RES_W-1:0] fifo_head;

  assign res_valid = dly_q[LAT-1];

  always_comb begin
    dly_d = (dly_q << 1) | LAT'(issue_valid_i);
    if (flush_i) begin
      dly_d = '0;
    end
  end

  // Pops happen only when the hold register is about to be (re)loaded.
  always_comb begin
    state_d  = state_q;
    hold_d   = hold_q;
    fifo_pop = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          hold_d   = fifo_head;
          state_d  = HI;
        end
      end
      HI: begin
        if (byte_ready_i) begin
          state_d = LO;
        end
      end
      LO: begin
        if (byte_ready_i) begin
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            hold_d   = fifo_head;
            state_d  = HI;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (flush_i) begin
      state_d  = IDLE;
      hold_d   = '0;
      fifo_pop = 1'b0;
    end
  end

  assign fifo_push = res_valid && (!fifo_full || fifo_pop) && !flush_i;

  always_comb begin
    overflow_d = overflow_q | (res_valid && fifo_full && !fifo_pop);
    if (flush_i) begin
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk_p_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      dly_q      <= '0;
      hold_q     <= '0;
      state_q    <= IDLE;
      overflow_q <= 1'b0;
    end else begin
      dly_q      <= dly_d;
      hold_q     <= hold_d;
      state_q    <= state_d;
      overflow_q <= overflow_d;
    end
  end

  alu_res_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (RES_W)
  ) u_fifo (
    .clk_p_i     (clk_p_i),
    .reset_n_i   (reset_n_i),
    .clear_i     (flush_i),
    .push_i      (fifo_push),
    .push_data_i (alu_data_i),
    .pop_i       (fifo_pop),
    .head_o      (fifo_head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .count_o     (count_o)
  );

  always_comb begin
    byte_o       = 8'h00;
    byte_valid_o = 1'b0;
    byte_last_o  = 1'b0;
    case (state_q)
      HI: begin
        byte_o       = res_byte(hold_q, 1'b1);
        byte_valid_o = 1'b1;
      end
      LO: begin
        byte_o       = res_byte(hold_q, 1'b0);
        byte_valid_o = 1'b1;
        byte_last_o  = 1'b1;
      end
      default: ;
    endcase
  end

  assign overflow_o = overflow_q;

endmodule

// File: tb/tb_alu_result_serializer.sv
// Self-checking bench: a 2-cycle ALU model feeds the serializer, a scoreboard
// queue holds the expected byte stream, and hand sequences cover timing corners.
module tb_alu_result_serializer;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  localparam logic [1:0] OP_ADD  = 2'd0;
  localparam logic [1:0] OP_SUB  = 2'd1;
  localparam logic [1:0] OP_MUL  = 2'd2;
  localparam logic [1:0] OP_PASS = 2'd3;

  typedef struct {
    logic [1:0]  op;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] res;
  } vec_t;

  typedef struct packed {
    logic [7:0] b;
    logic       last;
  } exp_t;

  logic          clk_p;
  logic          reset_n;
  logic          issue_valid;
  logic [15:0]   alu_data;
  logic          flush;
  logic [7:0]    byte_out;
  logic          byte_valid;
  logic          byte_ready;
  logic          byte_last;
  logic [CW-1:0] count;
  logic          overflow;

  logic [1:0]    alu_op;
  logic [7:0]    alu_a, alu_b;
  logic [15:0]   alu_s1, alu_s2;

  int            n_checks;
  int            n_fails;
  exp_t          exp_q[$];
  vec_t          vecs[8];

  logic          stall;
  logic [7:0]    stall_byte;

  alu_result_serializer #(.DEPTH(DEPTH), .LAT(2)) dut (
    .clk_p_i       (clk_p),
    .reset_n_i     (reset_n),
    .issue_valid_i (issue_valid),
    .alu_data_i    (alu_data),
    .flush_i       (flush),
    .byte_o        (byte_out),
    .byte_valid_o  (byte_valid),
    .byte_ready_i  (byte_ready),
    .byte_last_o   (byte_last),
    .count_o       (count),
    .overflow_o    (overflow)
  );

  initial begin
    clk_p = 1'b0;
    forever #5 clk_p = ~clk_p;
  end

  function automatic logic [15:0] aluModel(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
    logic [15:0] ea, eb;
    ea = {8'h00, a};
    eb = {8'h00, b};
    case (op)
      OP_ADD:  return ea + eb;
      OP_SUB:  return ea - eb;
      OP_MUL:  return ea * eb;
      default: return {a, b};
    endcase
  endfunction

  // Two-stage ALU: operands presented in cycle t appear on alu_data in cycle t+2.
  always @(posedge clk_p) begin
    alu_s1 <= aluModel(alu_op, alu_a, alu_b);
    alu_s2 <= alu_s1;
  end
  assign alu_data = alu_s2;

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                               input logic [15:0] res, input bit drop);
    exp_t e;
    alu_op      = op;
    alu_a       = a;
    alu_b       = b;
    issue_valid = 1'b1;
    if (!drop) begin
      e.b = res[15:8]; e.last = 1'b0; exp_q.push_back(e);
      e.b = res[7:0];  e.last = 1'b1; exp_q.push_back(e);
    end
    @(negedge clk_p);
    issue_valid = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk_p);
  endtask

  task automatic drainOutput(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk_p);
      n++;
    end
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fails++;
      $display("[TB] FAIL %s: timeout with %0d bytes outstanding, expected 0", name, exp_q.size());
      exp_q.delete();
    end else begin
      checkOutput({name, "_idle"}, 16'(byte_valid), 16'd0);
    end
  endtask

  // Scoreboard monitor samples mid second half-cycle, after the driver has settled.
  always begin
    @(negedge clk_p);
    #2;
    if (!reset_n) begin
      stall = 1'b0;
    end else begin
      if (stall && byte_valid) begin
        checkOutput("stable_byte", 16'(byte_out), 16'(stall_byte));
      end
      if (byte_valid && byte_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fails++;
          $display("[TB] FAIL unexpected_byte: got %h, expected no byte", byte_out);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          checkOutput("stream_byte", 16'(byte_out), 16'(e.b));
          checkOutput("stream_last", 16'(byte_last), 16'(e.last));
        end
      end
      stall      = byte_valid && !byte_ready;
      stall_byte = byte_out;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    n_checks    = 0;
    n_fails     = 0;
    stall       = 1'b0;
    stall_byte  = 8'h00;
    reset_n     = 1'b0;
    issue_valid = 1'b0;
    flush       = 1'b0;
    byte_ready  = 1'b1;
    alu_op      = OP_ADD;
    alu_a       = 8'h00;
    alu_b       = 8'h00;

    vecs[0] = '{OP_ADD,  8'h03, 8'h05, 16'h0008};
    vecs[1] = '{OP_MUL,  8'hFF, 8'hFF, 16'hFE01};
    vecs[2] = '{OP_ADD,  8'hFF, 8'h01, 16'h0100};
    vecs[3] = '{OP_SUB,  8'h10, 8'h01, 16'h000F};
    vecs[4] = '{OP_SUB,  8'h00, 8'h01, 16'hFFFF};
    vecs[5] = '{OP_MUL,  8'h12, 8'h34, 16'h03A8};
    vecs[6] = '{OP_PASS, 8'hA5, 8'h5A, 16'hA55A};
    vecs[7] = '{OP_ADD,  8'h7F, 8'h01, 16'h0080};

    // Reset state
    #2;
    checkOutput("rst_valid",    16'(byte_valid), 16'd0);
    checkOutput("rst_byte",     16'(byte_out),   16'h00);
    checkOutput("rst_last",     16'(byte_last),  16'd0);
    checkOutput("rst_count",    16'(count),      16'd0);
    checkOutput("rst_overflow", 16'(overflow),   16'd0);
    cycles(2);
    reset_n = 1'b1;
    cycles(1);

    // Exact latency of a single ADD
    applyStimulus(OP_ADD, 8'h03, 8'h05, 16'h0008, 1'b0);
    cycles(1);
    checkOutput("add_t2_valid", 16'(byte_valid), 16'd0);
    checkOutput("add_t2_count", 16'(count), 16'd0);
    cycles(1);
    checkOutput("add_t3_valid", 16'(byte_valid), 16'd0);
    checkOutput("add_t3_count", 16'(count), 16'd1);
    cycles(1);
    checkOutput("add_t4_valid", 16'(byte_valid), 16'd1);
    checkOutput("add_t4_byte",  16'(byte_out),   16'h00);
    checkOutput("add_t4_last",  16'(byte_last),  16'd0);
    cycles(1);
    checkOutput("add_t5_valid", 16'(byte_valid), 16'd1);
    checkOutput("add_t5_byte",  16'(byte_out),   16'h08);
    checkOutput("add_t5_last",  16'(byte_last),  16'd1);
    cycles(1);
    checkOutput("add_t6_valid", 16'(byte_valid), 16'd0);

    // Table of single operations
    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res, 1'b0);
      drainOutput($sformatf("vec%0d", i));
    end

    // Backpressure fills the FIFO, a sixth result overflows
    byte_ready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      applyStimulus(OP_PASS, 8'h00, 8'(i), 16'(i), 1'b0);
    end
    cycles(3);
    checkOutput("full_count",    16'(count),      16'd4);
    checkOutput("full_overflow", 16'(overflow),   16'd0);
    checkOutput("full_byte",     16'(byte_out),   16'h00);
    checkOutput("full_valid",    16'(byte_valid), 16'd1);
    applyStimulus(OP_PASS, 8'h00, 8'h06, 16'h0006, 1'b1);
    cycles(2);
    checkOutput("ovf_set",   16'(overflow), 16'd1);
    checkOutput("ovf_count", 16'(count),    16'd4);
    byte_ready = 1'b1;
    drainOutput("ovf_drain");
    checkOutput("ovf_sticky", 16'(overflow), 16'd1);

    // Three back-to-back results stream without a bubble
    applyStimulus(OP_ADD, 8'h11, 8'h22, 16'h0033, 1'b0);
    applyStimulus(OP_MUL, 8'h02, 8'h80, 16'h0100, 1'b0);
    applyStimulus(OP_PASS, 8'hC3, 8'h3C, 16'hC33C, 1'b0);
    checkOutput("b2b_pre_valid", 16'(byte_valid), 16'd0);
    for (int i = 0; i < 6; i++) begin
      cycles(1);
      checkOutput($sformatf("b2b_valid%0d", i), 16'(byte_valid), 16'd1);
      checkOutput($sformatf("b2b_last%0d", i),  16'(byte_last),  16'(i % 2));
    end
    cycles(1);
    checkOutput("b2b_post_valid", 16'(byte_valid), 16'd0);
    drainOutput("b2b_drain");

    // Asynchronous reset while in HI with two entries queued
    byte_ready = 1'b0;
    applyStimulus(OP_PASS, 8'h01, 8'h01, 16'h0101, 1'b0);
    applyStimulus(OP_PASS, 8'h02, 8'h02, 16'h0202, 1'b0);
    applyStimulus(OP_PASS, 8'h03, 8'h03, 16'h0303, 1'b0);
    cycles(2);
    checkOutput("pre_rst_count", 16'(count),      16'd2);
    checkOutput("pre_rst_valid", 16'(byte_valid), 16'd1);
    checkOutput("pre_rst_ovf",   16'(overflow),   16'd1);
    #1 reset_n = 1'b0;
    #1;
    checkOutput("arst_valid",    16'(byte_valid), 16'd0);
    checkOutput("arst_count",    16'(count),      16'd0);
    checkOutput("arst_overflow", 16'(overflow),   16'd0);
    checkOutput("arst_byte",     16'(byte_out),   16'h00);
    exp_q.delete();
    cycles(2);
    reset_n    = 1'b1;
    byte_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cycles(1);
      checkOutput($sformatf("post_rst_quiet%0d", i), 16'(byte_valid), 16'd0);
    end
    applyStimulus(OP_PASS, 8'h12, 8'h34, 16'h1234, 1'b0);
    drainOutput("post_rst_drain");

    // Pop from LO and delayed push land on the same edge while full
    byte_ready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      applyStimulus(OP_PASS, 8'h40, 8'(i), {8'h40, 8'(i)}, 1'b0);
    end
    cycles(3);
    checkOutput("pp_full_count", 16'(count), 16'd4);
    applyStimulus(OP_PASS, 8'h40, 8'h06, 16'h4006, 1'b0);
    byte_ready = 1'b1;
    cycles(1);
    checkOutput("pp_lo_last",  16'(byte_last), 16'd1);
    checkOutput("pp_lo_count", 16'(count),     16'd4);
    cycles(1);
    checkOutput("pp_count",    16'(count),     16'd4);
    checkOutput("pp_overflow", 16'(overflow),  16'd0);
    checkOutput("pp_hi_last",  16'(byte_last), 16'd0);
    drainOutput("pp_drain");

    // Flush clears FIFO, overflow and an in-flight result
    byte_ready = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      applyStimulus(OP_PASS, 8'h50, 8'(i), {8'h50, 8'(i)}, i == 6);
    end
    cycles(2);
    checkOutput("fl_pre_ovf",   16'(overflow), 16'd1);
    checkOutput("fl_pre_count", 16'(count),    16'd4);
    applyStimulus(OP_PASS, 8'h5F, 8'h5F, 16'h5F5F, 1'b1);
    flush = 1'b1;
    exp_q.delete();
    cycles(1);
    flush = 1'b0;
    checkOutput("fl_count",    16'(count),      16'd0);
    checkOutput("fl_overflow", 16'(overflow),   16'd0);
    checkOutput("fl_valid",    16'(byte_valid), 16'd0);
    checkOutput("fl_byte",     16'(byte_out),   16'h00);
    byte_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cycles(1);
      checkOutput($sformatf("fl_quiet%0d", i), 16'(byte_valid), 16'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
